// File: rtl/controller_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : controller_fsm
//  Purpose  : Sequencing half of the processor controller. Holds the state
//             register, instruction register, memory fetch handshake,
//             run/halt control, retired-instruction counter and
//             memory-timeout error detection. currstate and instruction feed
//             the external combinational output decoder.
//  Ports    : clock       - system clock, rising-edge active
//             reset       - synchronous, active-high
//             run         - 1 = execute, 0 = stop at next instruction boundary
//             mem_data    - memory read data (instruction / operand word)
//             mem_ready   - mem_data valid this cycle
//             mem_req     - memory read request (FETCH, EXEC_L)
//             currstate   - registered state code, to output decoder
//             instruction - instruction register, to output decoder
//             load_strobe - write mem_data into Rx = instruction[5:3]
//             done        - final cycle of an instruction
//             busy        - not HALT and not ERROR
//             error       - in ERROR state
//             retired     - count of completed instructions (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module controller_fsm #(
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [7:0]           mem_data,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic [3:0]           currstate,
  output logic [7:0]           instruction,
  output logic                 load_strobe,
  output logic                 done,
  output logic                 busy,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] retired
);

  // State codes are shared with the output decoder and must not change.
  localparam logic [3:0] S_FETCH    = 4'b0000;
  localparam logic [3:0] S_DECODE   = 4'b0001;
  localparam logic [3:0] S_EXEC_AX1 = 4'b0010;
  localparam logic [3:0] S_EXEC_AX2 = 4'b0011;
  localparam logic [3:0] S_EXEC_AX3 = 4'b0100;
  localparam logic [3:0] S_EXEC_L   = 4'b0101;
  localparam logic [3:0] S_EXEC_M   = 4'b0110;
  localparam logic [3:0] S_HALT     = 4'b0111;
  localparam logic [3:0] S_ERROR    = 4'b1111;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;

  // Wait counter holds (waiting cycles so far - 1) during a stall, so the
  // TIMEOUT-th waiting cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  localparam logic [CNT_WIDTH-1:0] RET_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]           state_q,   state_d;
  logic [7:0]           instr_q,   instr_d;
  logic [7:0]           wait_q,    wait_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic w_mem_phase;
  logic w_timeout;
  logic w_complete;

  assign w_mem_phase = (state_q == S_FETCH) || (state_q == S_EXEC_L);
  assign w_timeout   = w_mem_phase && !mem_ready && (wait_q == WAIT_LAST);
  assign w_complete  = (state_q == S_EXEC_AX3) || (state_q == S_EXEC_M) ||
                       ((state_q == S_EXEC_L) && mem_ready);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_HALT;
      instr_q   <= 8'h00;
      wait_q    <= 8'h00;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    // The wait counter defaults to zero, which also clears it on entry to
    // FETCH/EXEC_L and on every cycle mem_ready is seen.
    wait_d    = 8'h00;
    retired_d = retired_q;

    case (state_q)
      S_HALT: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          instr_d = mem_data;
          state_d = S_DECODE;
        end else if (w_timeout) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        case (instr_q[7:6])
          OP_LOAD: state_d = S_EXEC_L;
          OP_MOVE: state_d = S_EXEC_M;
          default: state_d = S_EXEC_AX1;
        endcase
      end
      S_EXEC_AX1: state_d = S_EXEC_AX2;
      S_EXEC_AX2: state_d = S_EXEC_AX3;
      S_EXEC_AX3,
      S_EXEC_M: begin
        state_d = run ? S_FETCH : S_HALT;
      end
      S_EXEC_L: begin
        if (mem_ready) begin
          state_d = run ? S_FETCH : S_HALT;
        end else if (w_timeout) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_ERROR: state_d = S_ERROR;
      // Codes 1000-1110 are unreachable in normal operation; treat as fault.
      default: state_d = S_ERROR;
    endcase

    if (w_complete) retired_d = retired_q + RET_ONE;
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req     = w_mem_phase;
    load_strobe = (state_q == S_EXEC_L) && mem_ready;
    done        = w_complete;
    busy        = (state_q != S_HALT) && (state_q != S_ERROR);
    error       = (state_q == S_ERROR);
  end

  assign currstate   = state_q;
  assign instruction = instr_q;
  assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_controller_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controller_fsm
//  Purpose  : Self-checking bench for controller_fsm. A cycle-level model of
//             the instruction lifecycle is compared against the DUT on every
//             falling edge; directed sequences add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_controller_fsm;

  localparam int CNT_WIDTH = 8;
  localparam int TIMEOUT   = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 run = 1'b0;
  logic [7:0]           mem_data = 8'h00;
  logic                 mem_ready = 1'b0;
  logic                 mem_req;
  logic [3:0]           currstate;
  logic [7:0]           instruction;
  logic                 load_strobe;
  logic                 done;
  logic                 busy;
  logic                 error;
  logic [CNT_WIDTH-1:0] retired;

  always #5 clock = ~clock;

  controller_fsm #(.CNT_WIDTH(CNT_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .currstate   (currstate),
    .instruction (instruction),
    .load_strobe (load_strobe),
    .done        (done),
    .busy        (busy),
    .error       (error),
    .retired     (retired)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: tracks where we are in an instruction's life rather than a state
  // code. m_step counts cycles since the instruction word was accepted
  // (1 = decode, 2.. = execute).
  // --------------------------------------------------------------------------
  bit         m_valid = 0;
  bit         m_halt  = 1;
  bit         m_err   = 0;
  bit         m_fetch = 0;
  int         m_step  = 0;
  int         m_wait  = 0;
  logic [7:0] m_instr = 8'h00;
  int         m_ret   = 0;

  function automatic bit m_exec();
    return !m_halt && !m_err && !m_fetch && (m_step >= 2);
  endfunction

  function automatic bit m_load_phase();
    return m_exec() && (m_instr[7:6] == 2'b00);
  endfunction

  function automatic bit m_complete();
    if (!m_exec()) return 0;
    if (m_instr[7:6] == 2'b01) return 1;
    if (m_instr[7:6] == 2'b00) return mem_ready;
    return m_step == 4;
  endfunction

  function automatic int m_state_code();
    if (m_err)   return 15;
    if (m_halt)  return 7;
    if (m_fetch) return 0;
    if (m_step == 1) return 1;
    if (m_instr[7:6] == 2'b00) return 5;
    if (m_instr[7:6] == 2'b01) return 6;
    return m_step;  // ALU ops: execute cycles 2,3,4 map to AX1..AX3
  endfunction

  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_valid = 1; m_halt = 1; m_err = 0; m_fetch = 0;
      m_step = 0; m_wait = 0; m_instr = 8'h00; m_ret = 0;
    end else if (m_valid && !m_err) begin
      if (m_halt) begin
        if (run) begin m_halt = 0; m_fetch = 1; m_wait = 0; end
      end else if (m_fetch) begin
        if (mem_ready) begin
          m_instr = mem_data; m_fetch = 0; m_step = 1; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) m_err = 1;
        end
      end else if (m_complete()) begin
        m_ret  = (m_ret + 1) % (1 << CNT_WIDTH);
        m_step = 0;
        m_wait = 0;
        if (run) m_fetch = 1; else m_halt = 1;
      end else if (m_load_phase()) begin
        m_wait++;
        if (m_wait == TIMEOUT) m_err = 1;
      end else begin
        m_step++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (m_valid) begin
      chk("m_currstate",   currstate,   m_state_code());
      chk("m_instruction", instruction, m_instr);
      chk("m_retired",     retired,     m_ret);
      chk("m_mem_req",     mem_req,     !m_err && !m_halt && (m_fetch || m_load_phase()));
      chk("m_load_strobe", load_strobe, m_load_phase() && mem_ready);
      chk("m_done",        done,        m_complete());
      chk("m_busy",        busy,        !m_halt && !m_err);
      chk("m_error",       error,       m_err);
    end
  end

  // Advance one clock; inputs are changed 2 time units after the edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_state", currstate, 7);
    chk("rst_instr", instruction, 0);
    chk("rst_retired", retired, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);

    // ---------------- MOVE ----------------
    run = 1; mem_ready = 1; mem_data = 8'h53;
    step(); #1 chk("mv_fetch", currstate, 0); chk("mv_req", mem_req, 1);
    step(); #1 chk("mv_decode", currstate, 1); chk("mv_instr", instruction, 8'h53);
    step(); #1 chk("mv_exec_m", currstate, 6); chk("mv_done", done, 1);
    step(); mem_data = 8'h8A;
    #1 chk("mv_refetch", currstate, 0); chk("mv_retired", retired, 1);

    // ---------------- ADD, run dropped in AX2 ----------------
    step(); #1 chk("add_decode", currstate, 1); chk("add_instr", instruction, 8'h8A);
    step(); #1 chk("add_ax1", currstate, 2); chk("add_ax1_done", done, 0);
    step(); run = 0; #1 chk("add_ax2", currstate, 3);
    step(); #1 chk("add_ax3", currstate, 4); chk("add_ax3_done", done, 1);
    chk("add_ax3_instr", instruction, 8'h8A);
    step(); #1 chk("add_halt", currstate, 7); chk("add_busy", busy, 0);
    chk("add_retired", retired, 2);
    run = 1;
    step(); #1 chk("rerun_fetch", currstate, 0);

    // ---------------- LOAD, operand 3 cycles late ----------------
    mem_data = 8'h28;
    step(); mem_ready = 0; #1 chk("ld_decode", currstate, 1); chk("ld_instr", instruction, 8'h28);
    step(); #1 chk("ld_w1", currstate, 5); chk("ld_w1_req", mem_req, 1); chk("ld_w1_ls", load_strobe, 0);
    step(); #1 chk("ld_w2_req", mem_req, 1);
    step(); #1 chk("ld_w3_req", mem_req, 1); chk("ld_w3_done", done, 0);
    step(); mem_ready = 1;
    #1 chk("ld_w4_req", mem_req, 1); chk("ld_strobe", load_strobe, 1); chk("ld_done", done, 1);
    step(); mem_ready = 0;
    #1 chk("ld_next_fetch", currstate, 0); chk("ld_retired", retired, 3);
    chk("ld_strobe_off", load_strobe, 0);

    // ---------------- ready on the TIMEOUT-th waiting cycle ----------------
    repeat (TIMEOUT - 2) step();
    #1 chk("edge_wait", currstate, 0);
    step(); mem_ready = 1; mem_data = 8'h53;
    #1 chk("edge_last", currstate, 0);
    step(); #1 chk("edge_decode", currstate, 1); chk("edge_noerr", error, 0);
    step(); #1 chk("edge_exec", currstate, 6);
    step(); mem_ready = 0;
    #1 chk("edge_fetch", currstate, 0); chk("edge_retired", retired, 4);

    // ---------------- timeout into ERROR ----------------
    repeat (TIMEOUT - 1) step();
    #1 chk("to_last_wait", currstate, 0); chk("to_last_err", error, 0);
    step(); #1 chk("to_state", currstate, 15); chk("to_error", error, 1);
    chk("to_busy", busy, 0); chk("to_req", mem_req, 0);
    mem_ready = 1; run = 1;
    repeat (3) step();
    #1 chk("to_sticky", currstate, 15); chk("to_retired_hold", retired, 4);
    chk("to_instr_hold", instruction, 8'h53); chk("to_done", done, 0);

    // ---------------- reset recovery, then reset mid-instruction -------------
    reset = 1;
    step(); reset = 0;
    #1 chk("rec_state", currstate, 7); chk("rec_error", error, 0);
    mem_data = 8'h53;
    step(); step(); step();
    step(); mem_data = 8'h8A;
    #1 chk("mid_retired_pre", retired, 1);
    step(); step(); step(); reset = 1;
    #1 chk("mid_ax2", currstate, 3);
    step(); reset = 0;
    #1 chk("mid_halt", currstate, 7); chk("mid_instr", instruction, 0);
    chk("mid_retired", retired, 0); chk("mid_busy", busy, 0);

    // ---------------- 256 MOVEs: retired wraps ----------------
    mem_data = 8'h53;
    step();
    for (int i = 0; i < 256; i++) begin
      repeat (3) step();
      if (i == 254) begin
        #1 chk("wrap_255", retired, 255);
      end
    end
    #1 chk("wrap_zero", retired, 0); chk("wrap_state", currstate, 0);

    run = 0;
    repeat (4) step();
    #1 chk("end_halt", currstate, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
